// File: rtl/bank_burst_if.sv
// Command-side bus of the per-bank burst sequencer: command handshake,
// write-beat data request, read-beat return and status.
interface bank_burst_if #(
  parameter int unsigned DEVICE_WIDTH = 4,
  parameter int unsigned COLS         = 1024,
  parameter int unsigned CHWIDTH      = 5
);
  localparam int unsigned COLW = $clog2(COLS);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [2:0]              cmd;
  logic [CHWIDTH-1:0]      row_in;
  logic [COLW-1:0]         col_in;
  logic [DEVICE_WIDTH-1:0] wdata_in;
  logic                    wdata_req;
  logic [DEVICE_WIDTH-1:0] rdata_out;
  logic                    rdata_valid;
  logic                    row_open;
  logic                    err;

  modport master (
    output cmd_valid, cmd, row_in, col_in, wdata_in,
    input  cmd_ready, wdata_req, rdata_out, rdata_valid, row_open, err
  );

  modport slave (
    input  cmd_valid, cmd, row_in, col_in, wdata_in,
    output cmd_ready, wdata_req, rdata_out, rdata_valid, row_open, err
  );
endinterface

// File: rtl/bank_burst_ctrl.sv
// Per-bank command sequencer: decodes ACT/RD/WR/PRE/RDA/WRA, holds the open row
// and walks BL wrapped column beats into the Bank SRAM wrapper.
module bank_burst_ctrl #(
  parameter int unsigned DEVICE_WIDTH = 4,
  parameter int unsigned COLS         = 1024,
  parameter int unsigned BL           = 8,
  parameter int unsigned CHWIDTH      = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  bank_burst_if.slave              bus,
  output logic                     bank_rd_o_wr,
  output logic [CHWIDTH-1:0]       bank_row,
  output logic [$clog2(COLS)-1:0]  bank_column,
  output logic [DEVICE_WIDTH-1:0]  bank_dqin,
  input  logic [DEVICE_WIDTH-1:0]  bank_dqout
);
  localparam int unsigned COLW = $clog2(COLS);
  localparam int unsigned LW   = $clog2(BL);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_RDA = 3'd5;
  localparam logic [2:0] CMD_WRA = 3'd6;

  localparam logic [COLW-1:0] LOW_MASK = COLW'(BL - 1);

  typedef enum logic [1:0] {IDLE, OPEN, RDB, WRB} state_t;

  state_t            state, state_d;
  logic [CHWIDTH-1:0] row_d;
  logic [COLW-1:0]   col_d, col_wrap;
  logic [LW-1:0]     beat, beat_d;
  logic              auto_pre, auto_pre_d;
  logic              we_d, wreq_q, rd_beat, rd_beat_d;
  logic              rv_q, rv_d, err_q, err_d;
  logic              ready_q, open_q;
  logic              accept;

  // Next column inside the BL-aligned block; upper column bits never move.
  assign col_wrap = (bank_column & ~LOW_MASK) | ((bank_column + COLW'(1)) & LOW_MASK);
  assign accept   = bus.cmd_valid & ready_q;

  always_comb begin
    state_d    = state;
    row_d      = bank_row;
    col_d      = bank_column;
    beat_d     = beat;
    auto_pre_d = auto_pre;
    we_d       = 1'b0;
    rd_beat_d  = 1'b0;
    rv_d       = rd_beat;
    err_d      = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (bus.cmd)
            CMD_ACT: begin
              row_d   = bus.row_in;
              state_d = OPEN;
            end
            CMD_NOP, CMD_PRE: ;
            default: err_d = 1'b1;
          endcase
        end
      end
      OPEN: begin
        if (accept) begin
          unique case (bus.cmd)
            CMD_RD, CMD_RDA: begin
              state_d    = RDB;
              col_d      = bus.col_in;
              beat_d     = '0;
              auto_pre_d = (bus.cmd == CMD_RDA);
              rd_beat_d  = 1'b1;
            end
            CMD_WR, CMD_WRA: begin
              state_d    = WRB;
              col_d      = bus.col_in;
              beat_d     = '0;
              auto_pre_d = (bus.cmd == CMD_WRA);
              we_d       = 1'b1;
            end
            CMD_PRE: state_d = IDLE;
            CMD_NOP: ;
            default: err_d = 1'b1;
          endcase
        end
      end
      RDB, WRB: begin
        if (beat == LW'(BL - 1)) begin
          state_d = auto_pre ? IDLE : OPEN;
        end else begin
          beat_d    = beat + 1'b1;
          col_d     = col_wrap;
          rd_beat_d = (state == RDB);
          we_d      = (state == WRB);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bank_row     <= '0;
      bank_column  <= '0;
      beat         <= '0;
      auto_pre     <= 1'b0;
      bank_rd_o_wr <= 1'b0;
      wreq_q       <= 1'b0;
      rd_beat      <= 1'b0;
      rv_q         <= 1'b0;
      err_q        <= 1'b0;
      ready_q      <= 1'b1;
      open_q       <= 1'b0;
    end else begin
      state        <= state_d;
      bank_row     <= row_d;
      bank_column  <= col_d;
      beat         <= beat_d;
      auto_pre     <= auto_pre_d;
      bank_rd_o_wr <= we_d;
      wreq_q       <= we_d;
      rd_beat      <= rd_beat_d;
      rv_q         <= rv_d;
      err_q        <= err_d;
      ready_q      <= (state_d == IDLE) || (state_d == OPEN);
      open_q       <= (state_d != IDLE);
    end
  end

  // Bank already registers its read data, so the beat is passed straight through.
  assign bank_dqin       = bus.wdata_in;
  assign bus.rdata_out   = rv_q ? bank_dqout : '0;
  assign bus.rdata_valid = rv_q;
  assign bus.wdata_req   = wreq_q;
  assign bus.cmd_ready   = ready_q;
  assign bus.row_open    = open_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_bank_burst_ctrl.sv
// Bench for bank_burst_ctrl: directed scenarios plus random command traffic,
// checked every cycle against a cycle-scheduled behavioural model and a Bank SRAM model.
module tb_bank_burst_ctrl;
  localparam int unsigned DW   = 4;
  localparam int unsigned COLS = 1024;
  localparam int unsigned BL   = 8;
  localparam int unsigned CHW  = 5;
  localparam int unsigned COLW = 10;
  localparam int unsigned MEMN = (1 << CHW) * COLS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0]   wd = '0;
  logic            bank_rd_o_wr;
  logic [CHW-1:0]  bank_row;
  logic [COLW-1:0] bank_column;
  logic [DW-1:0]   bank_dqin;
  logic [DW-1:0]   bank_dqout;

  bank_burst_if #(.DEVICE_WIDTH(DW), .COLS(COLS), .CHWIDTH(CHW)) bif ();

  bank_burst_ctrl #(.DEVICE_WIDTH(DW), .COLS(COLS), .BL(BL), .CHWIDTH(CHW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bif),
    .bank_rd_o_wr (bank_rd_o_wr),
    .bank_row     (bank_row),
    .bank_column  (bank_column),
    .bank_dqin    (bank_dqin),
    .bank_dqout   (bank_dqout)
  );

  always #5 clk = ~clk;
  assign bif.wdata_in = wd;

  // Bank SRAM: synchronous write, 1-cycle synchronous read.
  logic [DW-1:0] bank_mem [0:MEMN-1];
  always @(posedge clk) begin
    if (bank_rd_o_wr) bank_mem[{bank_row, bank_column}] <= bank_dqin;
    bank_dqout <= bank_mem[{bank_row, bank_column}];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit dir_mode = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Write data: counting 1..BL during directed write bursts, random otherwise.
  int wseq = 0;
  always @(posedge clk) begin
    #1;
    if (dir_mode && bif.wdata_req) begin
      wd = DW'(wseq + 1);
      wseq++;
    end else begin
      wd = DW'($urandom);
      wseq = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Behavioural model: each accepted command schedules outputs on absolute cycle numbers.
  bit              m_open;
  logic [CHW-1:0]  m_row;
  int              free_at;
  int              close_at;
  logic [COLW-1:0] wr_col [int];
  logic [COLW-1:0] rd_col [int];
  logic [DW-1:0]   rv_data [int];
  bit              err_at [int];
  logic [DW-1:0]   ref_mem [0:MEMN-1];

  logic [COLW-1:0] col_log [$];
  logic [DW-1:0]   rdat_log [$];
  int              rv_cyc_log [$];
  int              err_cnt = 0;

  task automatic model_accept(input int c);
    int col;
    logic [COLW-1:0] bc;
    col = int'(bif.col_in);
    if (!m_open) begin
      if (bif.cmd == 3'd1) begin
        m_open = 1'b1;
        m_row  = bif.row_in;
      end else if (bif.cmd != 3'd0 && bif.cmd != 3'd4) begin
        err_at[c + 1] = 1'b1;
      end
    end else begin
      case (bif.cmd)
        3'd2, 3'd5, 3'd3, 3'd6: begin
          for (int k = 0; k < int'(BL); k++) begin
            bc = COLW'((col / BL) * BL + ((col % BL) + k) % BL);
            if (bif.cmd == 3'd3 || bif.cmd == 3'd6) begin
              wr_col[c + 1 + k] = bc;
            end else begin
              rd_col[c + 1 + k]  = bc;
              rv_data[c + 2 + k] = ref_mem[{m_row, bc}];
            end
          end
          free_at = c + BL + 1;
          if (bif.cmd == 3'd5 || bif.cmd == 3'd6) close_at = c + BL + 1;
        end
        3'd4:       m_open = 1'b0;
        3'd1, 3'd7: err_at[c + 1] = 1'b1;
        default: ;
      endcase
    end
  endtask

  bit ew, er, ev, ee, rdy;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_cmd_ready", 32'(bif.cmd_ready), 1);
      chk("rst_row_open", 32'(bif.row_open), 0);
      chk("rst_bank_row", 32'(bank_row), 0);
      chk("rst_bank_column", 32'(bank_column), 0);
      chk("rst_rd_o_wr", 32'(bank_rd_o_wr), 0);
      chk("rst_wdata_req", 32'(bif.wdata_req), 0);
      chk("rst_rdata_valid", 32'(bif.rdata_valid), 0);
      chk("rst_rdata_out", 32'(bif.rdata_out), 0);
      chk("rst_err", 32'(bif.err), 0);
      m_open = 1'b0; m_row = '0; free_at = 0; close_at = -1;
      wr_col.delete(); rd_col.delete(); rv_data.delete(); err_at.delete();
    end else begin
      if (close_at == cyc) m_open = 1'b0;
      ew  = wr_col.exists(cyc);
      er  = rd_col.exists(cyc);
      ev  = rv_data.exists(cyc);
      ee  = err_at.exists(cyc);
      rdy = (cyc >= free_at);
      chk("cmd_ready", 32'(bif.cmd_ready), 32'(rdy));
      chk("row_open", 32'(bif.row_open), 32'(m_open));
      chk("err", 32'(bif.err), 32'(ee));
      chk("bank_rd_o_wr", 32'(bank_rd_o_wr), 32'(ew));
      chk("wdata_req", 32'(bif.wdata_req), 32'(ew));
      chk("rdata_valid", 32'(bif.rdata_valid), 32'(ev));
      chk("bank_dqin", 32'(bank_dqin), 32'(bif.wdata_in));
      if (ew) chk("wr_column", 32'(bank_column), 32'(wr_col[cyc]));
      if (er) chk("rd_column", 32'(bank_column), 32'(rd_col[cyc]));
      if (ev) chk("rdata_out", 32'(bif.rdata_out), 32'(rv_data[cyc]));
      if (m_open) chk("bank_row", 32'(bank_row), 32'(m_row));
      if (ew) ref_mem[{m_row, wr_col[cyc]}] = bif.wdata_in;
      if (bif.cmd_valid && rdy) model_accept(cyc);
    end
    if (bank_rd_o_wr) col_log.push_back(bank_column);
    if (bif.rdata_valid) begin
      rdat_log.push_back(bif.rdata_out);
      rv_cyc_log.push_back(cyc);
    end
    if (bif.err) err_cnt++;
  end

  int last_acc;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] c, input int r, input int col);
    int n = 0;
    bif.cmd_valid = 1'b1;
    bif.cmd       = c;
    bif.row_in    = CHW'(r);
    bif.col_in    = COLW'(col);
    @(negedge clk);
    while (!bif.cmd_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!bif.cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout cmd=%0d got=not_ready expected=ready", c);
    end
    last_acc = cyc;
    @(posedge clk);
    #1;
    bif.cmd_valid = 1'b0;
    bif.cmd       = 3'd0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bif.cmd_ready && n < 100) begin
      tick(1);
      n++;
    end
    if (!bif.cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout got=not_ready expected=ready");
    end
  endtask

  logic [COLW-1:0] exp_cols [8] = '{10'h00E, 10'h00F, 10'h008, 10'h009,
                                    10'h00A, 10'h00B, 10'h00C, 10'h00D};

  initial begin
    #1000000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, b_rd, b_col, b_err;
    logic [2:0] c;
    for (int i = 0; i < int'(MEMN); i++) begin
      bank_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    bif.cmd_valid = 1'b0;
    bif.cmd       = 3'd0;
    bif.row_in    = '0;
    bif.col_in    = '0;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Write 1..8 at col 0x10 of row 5, read it back.
    send(3'd1, 5, 0);
    send(3'd3, 0, 'h10);
    wait_ready();
    b_rd = rdat_log.size();
    send(3'd2, 0, 'h10);
    acc = last_acc;
    wait_ready();
    tick(2);
    chk("rd_beats", 32'(rdat_log.size() - b_rd), 8);
    for (int i = 0; i < 8; i++)
      if (b_rd + i < rdat_log.size()) chk("rd_data_lit", 32'(rdat_log[b_rd + i]), 32'(i + 1));
    if (b_rd + 7 < rdat_log.size()) begin
      chk("rd_first_latency", 32'(rv_cyc_log[b_rd] - acc), 2);
      chk("rd_consecutive", 32'(rv_cyc_log[b_rd + 7] - rv_cyc_log[b_rd]), 7);
    end

    // Wrapped column sequence inside the 8-aligned block.
    b_col = col_log.size();
    send(3'd3, 0, 'h0E);
    wait_ready();
    chk("wr_wrap_beats", 32'(col_log.size() - b_col), 8);
    for (int i = 0; i < 8; i++)
      if (b_col + i < col_log.size()) chk("wr_wrap_col_lit", 32'(col_log[b_col + i]), 32'(exp_cols[i]));

    // Read with no row open.
    send(3'd4, 0, 0);
    b_err = err_cnt;
    b_rd  = rdat_log.size();
    send(3'd2, 0, 'h33);
    tick(3);
    chk("rd_closed_err", 32'(err_cnt - b_err), 1);
    chk("rd_closed_no_rv", 32'(rdat_log.size() - b_rd), 0);
    chk("rd_closed_row_open", 32'(bif.row_open), 0);

    // ACT while a row is open.
    send(3'd1, 5, 0);
    b_err = err_cnt;
    send(3'd1, 9, 0);
    tick(2);
    chk("act_open_err", 32'(err_cnt - b_err), 1);
    chk("act_open_row", 32'(bank_row), 5);
    chk("act_open_row_open", 32'(bif.row_open), 1);

    // Auto-precharge write closes the row at T+BL+1.
    send(3'd6, 0, 0);
    acc = last_acc;
    tick(BL - 1);
    chk("wra_busy_ready", 32'(bif.cmd_ready), 0);
    chk("wra_busy_open", 32'(bif.row_open), 1);
    tick(1);
    chk("wra_done_ready", 32'(bif.cmd_ready), 1);
    chk("wra_done_open", 32'(bif.row_open), 0);
    chk("wra_done_cycle", 32'(cyc - acc), BL + 1);
    b_err = err_cnt;
    send(3'd2, 0, 0);
    tick(2);
    chk("wra_then_rd_err", 32'(err_cnt - b_err), 1);

    // Reset in the middle of a read burst.
    send(3'd1, 3, 0);
    send(3'd2, 0, 'h20);
    tick(2);
    chk("pre_rst_rv", 32'(bif.rdata_valid), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_rv", 32'(bif.rdata_valid), 0);
    chk("rst_mid_open", 32'(bif.row_open), 0);
    chk("rst_mid_ready", 32'(bif.cmd_ready), 1);
    tick(2);
    rst = 1'b0;
    tick(1);
    b_rd = rdat_log.size();
    send(3'd1, 3, 0);
    send(3'd2, 0, 'h20);
    wait_ready();
    tick(2);
    chk("post_rst_rd_beats", 32'(rdat_log.size() - b_rd), 8);

    // Random traffic against the model.
    dir_mode = 1'b0;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 99)) inside
        [0:17]:  c = 3'd1;
        [18:35]: c = 3'd2;
        [36:53]: c = 3'd3;
        [54:63]: c = 3'd4;
        [64:71]: c = 3'd5;
        [72:79]: c = 3'd6;
        [80:94]: c = 3'd0;
        default: c = 3'd7;
      endcase
      send(c, $urandom_range(0, 3), $urandom_range(0, COLS - 1));
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
      if (i == 200) begin
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
      end
    end
    tick(BL + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
